// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the digit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // A single-step adder still needs a one-bit counter to keep the datapath uniform.
    function automatic int cnt_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// rtl/serial_adder_fa_slice.sv - combinational DIGIT-bit ripple adder of full-adder cells
module fa_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    // Each cell: half adder on x,y, half adder on the partial sum and carry, OR of the carries.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic p;
        logic g1;
        logic g2;
        assign p        = x[i] ^ y[i];
        assign g1       = x[i] & y[i];
        assign s[i]     = p ^ c[i];
        assign g2       = p & c[i];
        assign c[i+1]   = g1 | g2;
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle adder reusing one DIGIT-wide slice WIDTH/DIGIT times
import serial_adder_pkg::*;

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] s;
    logic             co;
    logic             last;

    fa_slice #(.DIGIT(DIGIT)) u_slice (
        .x  (a_sr[DIGIT-1:0]),
        .y  (b_sr[DIGIT-1:0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

    assign last   = (cnt == CW'(STEPS - 1));
    // New digit enters at the top so after STEPS shifts the LSB digit sits at bit 0.
    assign sum_nx = (sum_r >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum_r <= sum_nx;
                    carry <= co;
                    a_sr  <= a_sr >> DIGIT;
                    b_sr  <= b_sr >> DIGIT;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_r <= co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed and scoreboarded checks of serial_adder
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_ready;
    logic       in_valid8  [3];
    logic       in_ready8  [3];
    logic       out_valid8 [3];
    logic [7:0] sum8       [3];
    logic       cout8      [3];

    logic        in_valid16;
    logic        in_ready16;
    logic        out_valid16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic [15:0] sum16;
    logic        cout16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid8[0]), .in_ready(in_ready8[0]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid8[0]), .out_ready(out_ready),
        .sum(sum8[0]), .cout(cout8[0]));

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid8[1]), .in_ready(in_ready8[1]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid8[1]), .out_ready(out_ready),
        .sum(sum8[1]), .cout(cout8[1]));

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8[2]), .in_ready(in_ready8[2]),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid8[2]), .out_ready(out_ready),
        .sum(sum8[2]), .cout(cout8[2]));

    serial_adder #(.WIDTH(16), .DIGIT(2)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready),
        .sum(sum16), .cout(cout16));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation to 8-bit instance idx; leaves the bench 1 time unit after the edge
    // where out_valid is first seen high.
    task automatic run8(input int idx, input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] esum, input logic ecout, input int elat, input string name);
        int lat;
        lat = 0;
        while (!in_ready8[idx] && lat < 50) begin
            tick();
            lat++;
        end
        a = va;
        b = vb;
        cin = vc;
        in_valid8[idx] = 1'b1;
        tick();
        in_valid8[idx] = 1'b0;
        a = ~va;
        b = ~vb;
        cin = ~vc;
        lat = 0;
        while (!out_valid8[idx] && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        checks++;
        if (sum8[idx] !== esum || cout8[idx] !== ecout) begin
            errors++;
            $display("FAIL %s result: got cout=%b sum=%h expected cout=%b sum=%h",
                     name, cout8[idx], sum8[idx], ecout, esum);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready8[i] !== 1'b0 || out_valid8[i] !== 1'b0 || sum8[i] !== 8'h00 || cout8[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d]: got in_ready=%b out_valid=%b sum=%h cout=%b expected 0 0 00 0",
                         i, in_ready8[i], out_valid8[i], sum8[i], cout8[i]);
            end
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready8[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release[%0d]: got in_ready=%b expected 1", i, in_ready8[i]);
            end
        end
        tick();
    endtask

    task automatic test_basic();
        run8(0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8, "zero_d1");
        tick();
        run8(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8, "wrap_d1");
        tick();
        run8(0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8, "a5_5a_cin_d1");
        tick();
        run8(0, 8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, 8, "7f_01_cin_d1");
        tick();
    endtask

    task automatic test_digit();
        run8(1, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 2, "3c_0f_d4");
        tick();
        run8(2, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1, "3c_0f_d8");
        tick();
        run8(2, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1, "wrap_d8");
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        run8(0, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 8, "bp_d1");
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 37);
            b = 8'h11;
            in_valid8[0] = 1'b1;
            tick();
            checks++;
            if (sum8[0] !== 8'h2C || cout8[0] !== 1'b1 || out_valid8[0] !== 1'b1 || in_ready8[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got sum=%h cout=%b out_valid=%b in_ready=%b expected 2c 1 1 0",
                         i, sum8[0], cout8[0], out_valid8[0], in_ready8[0]);
            end
        end
        in_valid8[0] = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid8[0] !== 1'b0 || in_ready8[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid8[0], in_ready8[0]);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int seen;
        a = 8'hFF;
        b = 8'h01;
        cin = 1'b0;
        in_valid8[0] = 1'b1;
        tick();
        in_valid8[0] = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready8[0] !== 1'b1 || out_valid8[0] !== 1'b0 || sum8[0] !== 8'h00) begin
            errors++;
            $display("FAIL midop_reset: got in_ready=%b out_valid=%b sum=%h expected 1 0 00",
                     in_ready8[0], out_valid8[0], sum8[0]);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid8[0]) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midop_no_output: got %0d out_valid cycles expected 0", seen);
        end
        run8(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8, "after_reset_d1");
        tick();
    endtask

    task automatic test_random16();
        logic [16:0] exp;
        int          wait_cnt;
        logic        done;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin16 = 1'($urandom);
            exp = {1'b0, a16} + {1'b0, b16} + {16'h0000, cin16};
            in_valid16 = 1'b1;
            wait_cnt = 0;
            while (!in_ready16 && wait_cnt < 50) begin
                tick();
                wait_cnt++;
            end
            tick();
            in_valid16 = 1'b0;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            done = 1'b0;
            for (int k = 0; k < 100 && !done; k++) begin
                out_ready = 1'($urandom);
                #1;
                if (out_valid16 && out_ready) begin
                    done = 1'b1;
                    checks++;
                    if ({cout16, sum16} !== exp) begin
                        errors++;
                        $display("FAIL rand16[%0d]: got %h expected %h", n, {cout16, sum16}, exp);
                    end
                end
                tick();
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL rand16_timeout[%0d]: got no result expected %h", n, exp);
            end
            out_ready = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        a = 8'h00;
        b = 8'h00;
        cin = 1'b0;
        out_ready = 1'b1;
        a16 = 16'h0000;
        b16 = 16'h0000;
        cin16 = 1'b0;
        in_valid16 = 1'b0;
        for (int i = 0; i < 3; i++) in_valid8[i] = 1'b0;
        test_reset();
        test_basic();
        test_digit();
        test_backpressure();
        test_reset_midop();
        test_random16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
